// File: rtl/ieee754_pkg.sv
// Shared IEEE-754 single-precision field definitions, decode helpers and
// converter state encoding. Used by the float-to-int converter and the adder.
package ieee754_pkg;

  localparam int WIDTH_NUMBER = 32;
  localparam int WIDTH_EXP    = 8;
  localparam int WIDTH_MANT   = 23;
  localparam int BIAS         = 127;

  localparam logic [WIDTH_EXP-1:0] EXP_MAX = 8'hFF;

  // Biased exponents that bound the integer-conversion ranges.
  // EXP_MIN_SHIFT is e = -1, EXP_ALIGN is e = 23, and EXP_SAT is e = 31.
  // At EXP_ALIGN the binary point already sits just right of bit 0.
  localparam logic [WIDTH_EXP-1:0] EXP_MIN_SHIFT = 8'(BIAS - 1);
  localparam logic [WIDTH_EXP-1:0] EXP_ALIGN     = 8'(BIAS + WIDTH_MANT);
  localparam logic [WIDTH_EXP-1:0] EXP_SAT       = 8'(BIAS + 31);

  localparam int COUNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    NEGATE = 2'd2,
    DONE   = 2'd3
  } conv_state_t;

  function automatic logic get_sign(input logic [WIDTH_NUMBER-1:0] x);
    return x[WIDTH_NUMBER-1];
  endfunction

  function automatic logic [WIDTH_EXP-1:0] get_exp(input logic [WIDTH_NUMBER-1:0] x);
    return x[WIDTH_NUMBER-2 -: WIDTH_EXP];
  endfunction

  function automatic logic [WIDTH_MANT-1:0] get_mant(input logic [WIDTH_NUMBER-1:0] x);
    return x[WIDTH_MANT-1:0];
  endfunction

endpackage

// File: rtl/ieee_classify.sv
// Combinational IEEE-754 single-precision operand classifier.
// It is driven from the exponent and fraction fields only.
module ieee_classify
  import ieee754_pkg::*;
(
  input  logic [WIDTH_EXP-1:0]  exp_field,
  input  logic [WIDTH_MANT-1:0] frac_field,
  output logic                  is_nan,
  output logic                  is_inf,
  output logic                  is_zero,
  output logic                  is_denormal,
  output logic                  too_small,
  output logic                  too_large
);

  logic exp_all_ones;
  logic exp_all_zeros;
  logic frac_nonzero;

  assign exp_all_ones  = (exp_field == EXP_MAX);
  assign exp_all_zeros = (exp_field == '0);
  assign frac_nonzero  = |frac_field;

  assign is_nan      = exp_all_ones && frac_nonzero;
  assign is_inf      = exp_all_ones && !frac_nonzero;
  assign is_zero     = exp_all_zeros && !frac_nonzero;
  assign is_denormal = exp_all_zeros && frac_nonzero;

  // Magnitude below 0.5 (zero and denormals included) or at least 2^31.
  assign too_small = (exp_field < EXP_MIN_SHIFT);
  assign too_large = (exp_field >= EXP_SAT) && !exp_all_ones;

endmodule

// File: rtl/ieee_to_int_converter.sv
// Iterative IEEE-754 single -> signed 32-bit integer converter, valid/ready on both sides.
// Define IEEE_TO_INT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncates toward zero.
module ieee_to_int_converter
  import ieee754_pkg::*;
#(
  parameter int          SHIFT_STEP = 1,
  parameter logic [31:0] SAT_POS    = 32'h7FFFFFFF,
  parameter logic [31:0] SAT_NEG    = 32'h80000000
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inputA,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] outputC,
  output logic        invalid,
  output logic        inexact
);

  localparam logic [31:0] MIN_INT_FLOAT = 32'hCF000000;

  conv_state_t state_reg;
  conv_state_t state_next;

  logic               sign_reg;
  logic               dir_left_reg;
  logic               guard_reg;
  logic               sticky_reg;
  logic [31:0]        acc_reg;
  logic [COUNT_W-1:0] count_reg;
  logic [31:0]        result_reg;
  logic               invalid_reg;
  logic               inexact_reg;

  logic                  a_sign;
  logic [WIDTH_EXP-1:0]  a_exp;
  logic [WIDTH_MANT-1:0] a_frac;
  logic                  is_nan;
  logic                  is_inf;
  logic                  is_zero;
  logic                  is_denormal;
  logic                  too_small;
  logic                  too_large;

  assign a_sign = get_sign(inputA);
  assign a_exp  = get_exp(inputA);
  assign a_frac = get_mant(inputA);

  ieee_classify u_classify (
    .exp_field   (a_exp),
    .frac_field  (a_frac),
    .is_nan      (is_nan),
    .is_inf      (is_inf),
    .is_zero     (is_zero),
    .is_denormal (is_denormal),
    .too_small   (too_small),
    .too_large   (too_large)
  );

  logic accept;
  logic is_special;
  logic is_min_int;

  assign accept     = in_valid && (state_reg == IDLE);
  assign is_min_int = (inputA == MIN_INT_FLOAT);
  assign is_special = is_nan || is_inf || too_large || too_small;

  logic [31:0] special_result;
  logic        special_invalid;
  logic        special_inexact;

  always_comb begin
    special_result  = '0;
    special_invalid = 1'b0;
    special_inexact = 1'b0;
    if (is_nan) begin
      special_result  = SAT_NEG;
      special_invalid = 1'b1;
    end else if (is_min_int) begin
      // -2^31 is representable, so it is the one e=31 input that does not saturate.
      special_result = 32'h80000000;
    end else if (is_inf || too_large) begin
      special_result  = a_sign ? SAT_NEG : SAT_POS;
      special_invalid = 1'b1;
    end else if (too_small) begin
      special_inexact = !is_zero;
    end
  end

  logic [31:0]        load_acc;
  logic               load_dir_left;
  logic [COUNT_W-1:0] load_count;

  assign load_acc      = {8'b0, !(is_zero || is_denormal), a_frac};
  assign load_dir_left = (a_exp >= EXP_ALIGN);
  assign load_count    = load_dir_left ? COUNT_W'(a_exp - EXP_ALIGN)
                                       : COUNT_W'(EXP_ALIGN - a_exp);

  logic [COUNT_W-1:0] shift_amt;
  logic [31:0]        acc_shifted;
  logic               guard_shifted;
  logic               sticky_shifted;

  assign shift_amt = (count_reg < COUNT_W'(SHIFT_STEP)) ? count_reg : COUNT_W'(SHIFT_STEP);

  // Up to SHIFT_STEP single-bit moves per cycle; on right shifts the previous guard
  // bit folds into sticky before the new outgoing bit becomes guard.
  always_comb begin
    acc_shifted    = acc_reg;
    guard_shifted  = guard_reg;
    sticky_shifted = sticky_reg;
    for (int i = 0; i < SHIFT_STEP; i++) begin
      if (COUNT_W'(i) < count_reg) begin
        if (dir_left_reg) begin
          acc_shifted = {acc_shifted[30:0], 1'b0};
        end else begin
          sticky_shifted = sticky_shifted | guard_shifted;
          guard_shifted  = acc_shifted[0];
          acc_shifted    = {1'b0, acc_shifted[31:1]};
        end
      end
    end
  end

  logic [31:0] mag;
  logic [31:0] neg_result;
  logic        neg_invalid;

  always_comb begin
`ifdef IEEE_TO_INT_ROUND_NEAREST_EN
    mag = acc_reg + {31'b0, guard_reg & (sticky_reg | acc_reg[0])};
`else
    mag = acc_reg;
`endif
    neg_result  = sign_reg ? -mag : mag;
    neg_invalid = 1'b0;
`ifdef IEEE_TO_INT_ROUND_NEAREST_EN
    if (mag[31]) begin
      neg_result  = sign_reg ? 32'h80000000 : SAT_POS;
      neg_invalid = !sign_reg;
    end
`endif
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = is_special ? DONE : SHIFT;
      SHIFT:   if (count_reg == shift_amt) state_next = NEGATE;
      NEGATE:  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sign_reg     <= 1'b0;
      dir_left_reg <= 1'b0;
      guard_reg    <= 1'b0;
      sticky_reg   <= 1'b0;
      acc_reg      <= '0;
      count_reg    <= '0;
      result_reg   <= '0;
      invalid_reg  <= 1'b0;
      inexact_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            sign_reg     <= a_sign;
            dir_left_reg <= load_dir_left;
            guard_reg    <= 1'b0;
            sticky_reg   <= 1'b0;
            acc_reg      <= load_acc;
            count_reg    <= load_count;
            if (is_special) begin
              result_reg  <= special_result;
              invalid_reg <= special_invalid;
              inexact_reg <= special_inexact;
            end
          end
        end
        SHIFT: begin
          acc_reg    <= acc_shifted;
          guard_reg  <= guard_shifted;
          sticky_reg <= sticky_shifted;
          count_reg  <= count_reg - shift_amt;
        end
        NEGATE: begin
          result_reg  <= neg_result;
          invalid_reg <= neg_invalid;
          inexact_reg <= guard_reg | sticky_reg;
        end
        default: ;
      endcase
    end
  end

  assign outputC = result_reg;
  assign invalid = invalid_reg;
  assign inexact = inexact_reg;

endmodule
